// File: rtl/stream_argmin_pkg.sv
// Shared utility package: elaboration-time sizing helpers
// and the state encoding of the streaming arg-min tracker.
package stream_argmin_pkg;

  function automatic int max(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min(int a, int b);
    return (a < b) ? a : b;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } argmin_state_t;

endpackage

// File: rtl/stream_argmin.sv
// Streaming arg-min: reports minimum, its index and beat
// count once per framed valid/ready input stream.
module stream_argmin
  import stream_argmin_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = 16,
  parameter bit SIGNED    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_min,
  output logic [IDX_WIDTH-1:0] out_index,
  output logic [IDX_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  localparam logic [IDX_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [IDX_WIDTH-1:0] CNT_ONE =
    IDX_WIDTH'(1);

  argmin_state_t state_q, state_d;

  logic [WIDTH-1:0]     min_q, min_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic acc;
  logic lt;
  logic sat;

  if (SIGNED) begin : g_signed
    assign lt = $signed(in_data) < $signed(min_q);
  end else begin : g_unsigned
    assign lt = in_data < min_q;
  end

  assign acc = in_valid && in_ready;
  assign sat = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      min_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          min_d   = in_data;
          idx_d   = '0;
          cnt_d   = CNT_ONE;
          ovf_d   = 1'b0;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (acc) begin
          if (lt) begin
            min_d = in_data;
            idx_d = sat ? CNT_MAX : cnt_q;
          end
          // Count pins at all-ones; overflow flags the lost beats
          if (sat) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_min   = min_q;
  assign out_index = idx_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_stream_argmin.sv
// Scoreboard bench: dut a is unsigned 16/16,
// dut b is signed with a 3-bit index/count.
module tb_stream_argmin;

  typedef struct packed {
    logic [15:0] mn;
    logic [15:0] idx;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  typedef logic [15:0] vec_t [16];

  logic clk = 1'b0;
  logic reset_n;

  logic        a_vld, a_rdy, a_lst, a_ovld, a_ordy, a_ovf;
  logic [15:0] a_dat, a_min, a_idx, a_cnt;

  logic        b_vld, b_rdy, b_lst, b_ovld, b_ordy, b_ovf;
  logic [15:0] b_dat, b_min;
  logic [2:0]  b_idx, b_cnt;

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  stream_argmin #(
    .WIDTH(16), .IDX_WIDTH(16), .SIGNED(1'b0)
  ) u_a (
    .clk(clk), .reset_n(reset_n),
    .in_valid(a_vld), .in_ready(a_rdy),
    .in_data(a_dat), .in_last(a_lst),
    .out_valid(a_ovld), .out_ready(a_ordy),
    .out_min(a_min), .out_index(a_idx),
    .out_count(a_cnt), .out_ovf(a_ovf)
  );

  stream_argmin #(
    .WIDTH(16), .IDX_WIDTH(3), .SIGNED(1'b1)
  ) u_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(b_vld), .in_ready(b_rdy),
    .in_data(b_dat), .in_last(b_lst),
    .out_valid(b_ovld), .out_ready(b_ordy),
    .out_min(b_min), .out_index(b_idx),
    .out_count(b_cnt), .out_ovf(b_ovf)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input string nm,
                     input exp_t got,
                     input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got min=%0h idx=%0d cnt=%0d ovf=%0b want min=%0h idx=%0d cnt=%0d ovf=%0b",
               nm, got.mn, got.idx, got.cnt, got.ovf,
               want.mn, want.idx, want.cnt, want.ovf);
    end
  endtask

  // Monitors: pop one expectation per output handshake
  always @(negedge clk) begin
    if (reset_n && a_ovld && a_ordy) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected got min=%0h want none", a_min);
      end else begin
        cmp("a_result", {a_min, a_idx, a_cnt, a_ovf},
            qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && b_ovld && b_ordy) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected got min=%0h want none", b_min);
      end else begin
        cmp("b_result",
            {b_min, 13'd0, b_idx, 13'd0, b_cnt, b_ovf},
            qb.pop_front());
      end
    end
  end

  task automatic beat(input bit sel,
                      input logic [15:0] d,
                      input logic l);
    int n;
    logic r;
    n = 0;
    if (!sel) begin
      a_vld = 1'b1; a_dat = d; a_lst = l;
    end else begin
      b_vld = 1'b1; b_dat = d; b_lst = l;
    end
    @(negedge clk);
    r = sel ? b_rdy : a_rdy;
    while (!r && n < 50) begin
      @(negedge clk);
      r = sel ? b_rdy : a_rdy;
      n++;
    end
    checks++;
    if (!r) begin
      errors++;
      $display("FAIL accept_timeout got ready=0 want 1 sel=%0d", sel);
    end
    @(posedge clk);
    #1;
    a_vld = 1'b0;
    b_vld = 1'b0;
  endtask

  task automatic frame(input bit sel, input int n,
                       input vec_t v, input exp_t e);
    if (!sel) qa.push_back(e);
    else      qb.push_back(e);
    for (int i = 0; i < n; i++) begin
      beat(sel, v[i], (i == n - 1));
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset_n = 1'b0;
    a_vld = 0; a_dat = 0; a_lst = 0; a_ordy = 1;
    b_vld = 0; b_dat = 0; b_lst = 0; b_ordy = 1;
    v = '{default: 16'h0};
    cyc(3);

    chk("rst_a_ovalid", a_ovld, 0);
    chk("rst_a_min",    a_min, 0);
    chk("rst_a_idx",    a_idx, 0);
    chk("rst_a_cnt",    a_cnt, 0);
    chk("rst_a_ovf",    a_ovf, 0);
    chk("rst_b_ovalid", b_ovld, 0);
    chk("rst_b_cnt",    b_cnt, 0);
    reset_n = 1'b1;
    cyc(1);
    chk("rst_a_inready", a_rdy, 1);
    chk("rst_b_inready", b_rdy, 1);

    // unsigned frame with a tie on the minimum
    v[0] = 5; v[1] = 3; v[2] = 9; v[3] = 3;
    frame(0, 4, v, '{16'd3, 16'd1, 16'd4, 1'b0});
    chk("t1_latency_ovalid", a_ovld, 1);
    chk("t1_hold_inready", a_rdy, 0);
    cyc(2);

    // same bits: signed on b, unsigned on a
    v[0] = 16'h0001; v[1] = 16'hFFFE; v[2] = 16'h7FFF;
    frame(1, 3, v, '{16'hFFFE, 16'd1, 16'd3, 1'b0});
    frame(0, 3, v, '{16'h0001, 16'd0, 16'd3, 1'b0});
    cyc(2);

    // one-beat frame
    v[0] = 42;
    frame(0, 1, v, '{16'd42, 16'd0, 16'd1, 1'b0});
    chk("t3_inready_low", a_rdy, 0);
    chk("t3_ovalid", a_ovld, 1);
    cyc(2);

    // backpressure for 5 cycles
    a_ordy = 1'b0;
    v[0] = 20; v[1] = 10;
    frame(0, 2, v, '{16'd10, 16'd1, 16'd2, 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_ovalid", a_ovld, 1);
      chk("t4_hold_inready", a_rdy, 0);
      chk("t4_hold_min", a_min, 10);
      chk("t4_hold_idx", a_idx, 1);
      chk("t4_hold_cnt", a_cnt, 2);
    end
    @(posedge clk); #1;
    a_ordy = 1'b1;
    @(posedge clk); #1;
    a_ordy = 1'b0;
    chk("t4_idle_inready", a_rdy, 1);
    chk("t4_idle_ovalid", a_ovld, 0);
    a_ordy = 1'b1;
    v[0] = 7;
    frame(0, 1, v, '{16'd7, 16'd0, 16'd1, 1'b0});
    cyc(2);

    // exactly 7 beats: count at max, no overflow
    for (int i = 0; i < 7; i++) v[i] = 16'(7 - i);
    frame(1, 7, v, '{16'd1, 16'd6, 16'd7, 1'b0});
    cyc(2);

    // 10 beats on a 3-bit counter, min on beat 9
    for (int i = 0; i < 10; i++) v[i] = 16'(100 - 10 * i);
    frame(1, 10, v, '{16'd10, 16'd7, 16'd7, 1'b1});
    cyc(2);
    v[0] = 5;
    frame(1, 1, v, '{16'd5, 16'd0, 16'd1, 1'b0});
    cyc(2);

    // reset discards a partial frame
    beat(0, 16'd1, 1'b0);
    beat(0, 16'd2, 1'b0);
    reset_n = 1'b0;
    cyc(2);
    chk("t6_rst_cnt", a_cnt, 0);
    chk("t6_rst_ovalid", a_ovld, 0);
    reset_n = 1'b1;
    cyc(1);
    v[0] = 8; v[1] = 6;
    frame(0, 2, v, '{16'd6, 16'd1, 16'd2, 1'b0});
    cyc(5);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
